control_sequencer: RTL and testbench

- Scheduler that sequences the load-enables of the datapath enable-register chain: sample input register, NUM_STAGES compute-stage registers, and the output register.
- An internal prescaler produces a periodic sample tick. Each accepted tick runs one fixed enable sequence.
- Also provides a single-shot trigger, a busy/done status, a wrapping sample counter and a sticky overrun flag.

---
 rtl/control_sequencer.sv | 107 ++++++++++
 tb/tb_control_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - sequences the sample/stage/output register load-enables
// A prescaler drives periodic sequences. A trigger starts one-shot sequences. Status outputs are registered.
module control_sequencer #(
   parameter int NUM_STAGES = 4,
   parameter int CLK_DIV    = 16,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  trig,
   input  logic                  clr_overrun,
   output logic                  en_sample,
   output logic [NUM_STAGES-1:0] en_stage,
   output logic                  en_out,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun,
   output logic [CNT_W-1:0]      sample_count
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STAGE, S_UPDATE} state_t;

   logic [PW-1:0]         cnt_q, cnt_d;
   logic                  tick;
   state_t                state_q;
   logic [IW-1:0]         idx_q;
   logic                  en_sample_q, en_out_q, busy_q, done_q, overrun_q;
   logic [NUM_STAGES-1:0] en_stage_q;
   logic [CNT_W-1:0]      count_q;

   always_comb begin
      tick  = run && (cnt_q == PW'(CLK_DIV - 1));
      cnt_d = (!run || tick) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   // Outputs are registered alongside the state so each one reflects the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         en_sample_q <= 1'b0;
         en_stage_q  <= '0;
         en_out_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         count_q     <= '0;
      end else begin
         en_sample_q <= 1'b0;
         en_stage_q  <= '0;
         en_out_q    <= 1'b0;
         done_q      <= 1'b0;

         if (tick && state_q != S_IDLE) overrun_q <= 1'b1;
         else if (clr_overrun)          overrun_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (tick || trig) begin
                  state_q     <= S_LOAD;
                  en_sample_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            S_LOAD: begin
               state_q    <= S_STAGE;
               idx_q      <= '0;
               en_stage_q <= NUM_STAGES'(1);
            end
            S_STAGE: begin
               if (idx_q == IW'(NUM_STAGES - 1)) begin
                  state_q  <= S_UPDATE;
                  en_out_q <= 1'b1;
                  done_q   <= 1'b1;
               end else begin
                  idx_q      <= idx_q + 1'b1;
                  en_stage_q <= NUM_STAGES'(1) << (idx_q + 1'b1);
               end
            end
            S_UPDATE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               count_q <= count_q + 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign en_sample    = en_sample_q;
   assign en_stage     = en_stage_q;
   assign en_out       = en_out_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign overrun      = overrun_q;
   assign sample_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
// Instance a: NUM_STAGES=4, CLK_DIV=8. Instance b: CLK_DIV=7 for overrun. Instance c: CNT_W=4 for wrap.
module tb_control_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   logic       a_reset, a_run, a_trig, a_clr;
   logic       a_en_sample, a_en_out, a_busy, a_done, a_overrun;
   logic [3:0] a_en_stage;
   logic [15:0] a_count;
   logic [7:0] a_obs;

   logic       b_reset, b_run, b_trig, b_clr;
   logic       b_en_sample, b_en_out, b_busy, b_done, b_overrun;
   logic [3:0] b_en_stage;
   logic [15:0] b_count;

   logic       c_reset, c_run, c_trig, c_clr;
   logic       c_en_sample, c_en_out, c_busy, c_done, c_overrun;
   logic [3:0] c_en_stage;
   logic [3:0] c_count;

   assign a_obs = {a_en_sample, a_en_stage, a_en_out, a_busy, a_done};

   control_sequencer #(.NUM_STAGES(4), .CLK_DIV(8), .CNT_W(16)) u_a (
      .clk(clk), .reset(a_reset), .run(a_run), .trig(a_trig), .clr_overrun(a_clr),
      .en_sample(a_en_sample), .en_stage(a_en_stage), .en_out(a_en_out),
      .busy(a_busy), .done(a_done), .overrun(a_overrun), .sample_count(a_count)
   );

   control_sequencer #(.NUM_STAGES(4), .CLK_DIV(7), .CNT_W(16)) u_b (
      .clk(clk), .reset(b_reset), .run(b_run), .trig(b_trig), .clr_overrun(b_clr),
      .en_sample(b_en_sample), .en_stage(b_en_stage), .en_out(b_en_out),
      .busy(b_busy), .done(b_done), .overrun(b_overrun), .sample_count(b_count)
   );

   control_sequencer #(.NUM_STAGES(4), .CLK_DIV(8), .CNT_W(4)) u_c (
      .clk(clk), .reset(c_reset), .run(c_run), .trig(c_trig), .clr_overrun(c_clr),
      .en_sample(c_en_sample), .en_stage(c_en_stage), .en_out(c_en_out),
      .busy(c_busy), .done(c_done), .overrun(c_overrun), .sample_count(c_count)
   );

   // Expected {en_sample, en_stage, en_out, busy, done} for cycle k of a sequence (k=0 is LOAD).
   function automatic logic [7:0] seq_vec(input int k);
      logic [3:0] one;
      one = 4'b0001;
      if (k == 0)                seq_vec = 8'b1_0000_0_1_0;
      else if (k >= 1 && k <= 4) seq_vec = {1'b0, one << (k - 1), 3'b010};
      else if (k == 5)           seq_vec = 8'b0_0000_1_1_1;
      else                       seq_vec = 8'h00;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #1;
      vecs++; if (a_obs !== 8'h00) begin errs++; $display("FAIL reset_obs: got %b want %b", a_obs, 8'h00); end
      vecs++; if (a_count !== 16'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", a_count); end
      vecs++; if (a_overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun: got %b want 0", a_overrun); end
      @(negedge clk);
      a_trig = 1'b1;
      step();
      a_trig = 1'b0;
      vecs++; if (a_obs !== 8'h00) begin errs++; $display("FAIL reset_hold_obs: got %b want %b", a_obs, 8'h00); end
      vecs++; if (c_count !== 4'd0) begin errs++; $display("FAIL reset_c_count: got %0d want 0", c_count); end
      a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
      step();
   endtask

   task automatic test_periodic();
      a_run = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         vecs++; if (a_obs !== 8'h00) begin errs++; $display("FAIL periodic_pre_idle[%0d]: got %b want %b", i, a_obs, 8'h00); end
      end
      for (int k = 0; k < 6; k++) begin
         step();
         vecs++; if (a_obs !== seq_vec(k)) begin errs++; $display("FAIL periodic_seq1[%0d]: got %b want %b", k, a_obs, seq_vec(k)); end
      end
      step();
      vecs++; if (a_obs !== 8'h00) begin errs++; $display("FAIL periodic_idle1: got %b want %b", a_obs, 8'h00); end
      vecs++; if (a_count !== 16'd1) begin errs++; $display("FAIL periodic_count1: got %0d want 1", a_count); end
      step();
      vecs++; if (a_obs !== 8'h00) begin errs++; $display("FAIL periodic_gap: got %b want %b", a_obs, 8'h00); end
      for (int k = 0; k < 6; k++) begin
         step();
         vecs++; if (a_obs !== seq_vec(k)) begin errs++; $display("FAIL periodic_seq2[%0d]: got %b want %b", k, a_obs, seq_vec(k)); end
      end
      step();
      vecs++; if (a_count !== 16'd2) begin errs++; $display("FAIL periodic_count2: got %0d want 2", a_count); end
      a_run = 1'b0;
      step();
   endtask

   task automatic test_single_shot();
      a_trig = 1'b1;
      step();
      a_trig = 1'b0;
      for (int k = 0; k < 6; k++) begin
         vecs++; if (a_obs !== seq_vec(k)) begin errs++; $display("FAIL single_seq[%0d]: got %b want %b", k, a_obs, seq_vec(k)); end
         step();
      end
      for (int i = 0; i < 10; i++) begin
         vecs++; if (a_obs !== 8'h00) begin errs++; $display("FAIL single_after[%0d]: got %b want %b", i, a_obs, 8'h00); end
         step();
      end
      vecs++; if (a_count !== 16'd3) begin errs++; $display("FAIL single_count: got %0d want 3", a_count); end
   endtask

   task automatic test_tick_and_trig();
      a_run = 1'b1;
      repeat (7) step();
      a_trig = 1'b1;
      step();
      a_trig = 1'b0;
      for (int k = 0; k < 6; k++) begin
         vecs++; if (a_obs !== seq_vec(k)) begin errs++; $display("FAIL both_seq[%0d]: got %b want %b", k, a_obs, seq_vec(k)); end
         step();
      end
      a_run = 1'b0;
      vecs++; if (a_count !== 16'd4) begin errs++; $display("FAIL both_count: got %0d want 4", a_count); end
      for (int i = 0; i < 4; i++) begin
         step();
         vecs++; if (a_obs !== 8'h00) begin errs++; $display("FAIL both_after[%0d]: got %b want %b", i, a_obs, 8'h00); end
      end
   endtask

   task automatic test_reset_mid_sequence();
      a_trig = 1'b1;
      step();
      a_trig = 1'b0;
      repeat (3) step();
      vecs++; if (a_obs !== seq_vec(3)) begin errs++; $display("FAIL rmid_stage2: got %b want %b", a_obs, seq_vec(3)); end
      #2 a_reset = 1'b1;
      #1;
      vecs++; if (a_obs !== 8'h00) begin errs++; $display("FAIL rmid_obs: got %b want %b", a_obs, 8'h00); end
      vecs++; if (a_count !== 16'd0) begin errs++; $display("FAIL rmid_count: got %0d want 0", a_count); end
      @(negedge clk);
      a_run = 1'b1;
      a_reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         vecs++; if (a_obs !== 8'h00) begin errs++; $display("FAIL rmid_pre_idle[%0d]: got %b want %b", i, a_obs, 8'h00); end
      end
      for (int k = 0; k < 6; k++) begin
         step();
         vecs++; if (a_obs !== seq_vec(k)) begin errs++; $display("FAIL rmid_seq[%0d]: got %b want %b", k, a_obs, seq_vec(k)); end
      end
      a_run = 1'b0;
      step();
      vecs++; if (a_count !== 16'd1) begin errs++; $display("FAIL rmid_count_after: got %0d want 1", a_count); end
   endtask

   task automatic test_overrun();
      b_run = 1'b1;
      repeat (4) step();
      b_trig = 1'b1;
      step();
      b_trig = 1'b0;
      vecs++; if (b_en_sample !== 1'b1) begin errs++; $display("FAIL ovr_load: got %b want 1", b_en_sample); end
      step();
      vecs++; if (b_overrun !== 1'b0) begin errs++; $display("FAIL ovr_before_tick: got %b want 0", b_overrun); end
      step();
      vecs++; if (b_overrun !== 1'b1) begin errs++; $display("FAIL ovr_set: got %b want 1", b_overrun); end
      vecs++; if (b_en_stage !== 4'b0010 || b_en_sample !== 1'b0) begin errs++; $display("FAIL ovr_tick_dropped: got stage %b sample %b want 0010 0", b_en_stage, b_en_sample); end
      repeat (4) step();
      vecs++; if (b_busy !== 1'b0 || b_count !== 16'd1) begin errs++; $display("FAIL ovr_seq_end: got busy %b count %0d want 0 1", b_busy, b_count); end
      repeat (2) step();
      vecs++; if (b_busy !== 1'b0) begin errs++; $display("FAIL ovr_no_extra: got busy %b want 0", b_busy); end
      step();
      vecs++; if (b_en_sample !== 1'b1 || b_overrun !== 1'b1) begin errs++; $display("FAIL ovr_next_tick: got sample %b overrun %b want 1 1", b_en_sample, b_overrun); end
      b_clr = 1'b1;
      step();
      b_clr = 1'b0;
      vecs++; if (b_overrun !== 1'b0) begin errs++; $display("FAIL ovr_clear: got %b want 0", b_overrun); end
      repeat (3) step();
      b_trig = 1'b1;
      step();
      b_trig = 1'b0;
      b_run = 1'b0;
      vecs++; if (b_overrun !== 1'b0 || b_en_out !== 1'b1) begin errs++; $display("FAIL ovr_trig_busy: got overrun %b en_out %b want 0 1", b_overrun, b_en_out); end
      step();
      step();
      vecs++; if (b_busy !== 1'b0 || b_count !== 16'd2) begin errs++; $display("FAIL ovr_trig_ignored: got busy %b count %0d want 0 2", b_busy, b_count); end
      b_run = 1'b1;
      repeat (4) step();
      b_trig = 1'b1;
      step();
      b_trig = 1'b0;
      step();
      b_clr = 1'b1;
      step();
      b_clr = 1'b0;
      vecs++; if (b_overrun !== 1'b1) begin errs++; $display("FAIL ovr_set_wins: got %b want 1", b_overrun); end
      step();
      b_clr = 1'b1;
      step();
      b_clr = 1'b0;
      b_run = 1'b0;
      vecs++; if (b_overrun !== 1'b0) begin errs++; $display("FAIL ovr_clear2: got %b want 0", b_overrun); end
      repeat (6) step();
      vecs++; if (b_busy !== 1'b0 || b_count !== 16'd3) begin errs++; $display("FAIL ovr_final: got busy %b count %0d want 0 3", b_busy, b_count); end
   endtask

   task automatic test_count_wrap();
      c_run = 1'b1;
      for (int n = 1; n <= 17; n++) begin
         int t;
         t = 0;
         while (c_done !== 1'b1 && t < 20) begin
            step();
            t++;
         end
         if (c_done !== 1'b1) begin
            vecs++; errs++;
            $display("FAIL wrap_timeout[%0d]: got done %b want 1 within 20 cycles", n, c_done);
            break;
         end
         step();
         vecs++; if (c_count !== 4'(n)) begin errs++; $display("FAIL wrap_count[%0d]: got %0d want %0d", n, c_count, 4'(n)); end
      end
      c_run = 1'b0;
   endtask

   initial begin
      a_reset = 1'b1; a_run = 1'b0; a_trig = 1'b0; a_clr = 1'b0;
      b_reset = 1'b1; b_run = 1'b0; b_trig = 1'b0; b_clr = 1'b0;
      c_reset = 1'b1; c_run = 1'b0; c_trig = 1'b0; c_clr = 1'b0;
      test_reset();
      test_periodic();
      test_single_shot();
      test_tick_and_trig();
      test_reset_mid_sequence();
      test_overrun();
      test_count_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
